// File: rtl/swi_conditioner_if.sv
// Switch-conditioning bus: raw switch levels in, debounced levels and edge/toggle events out.
interface swi_conditioner_if #(
  parameter int unsigned NBITS = 8
);
  logic [NBITS-1:0] swi_raw;
  logic [NBITS-1:0] swi_clean;
  logic [NBITS-1:0] swi_rise;
  logic [NBITS-1:0] swi_fall;
  logic [NBITS-1:0] swi_toggle;
  logic             swi_any_edge;

  modport master (
    output swi_raw,
    input  swi_clean,
    input  swi_rise,
    input  swi_fall,
    input  swi_toggle,
    input  swi_any_edge
  );

  modport slave (
    input  swi_raw,
    output swi_clean,
    output swi_rise,
    output swi_fall,
    output swi_toggle,
    output swi_any_edge
  );
endinterface

// File: rtl/swi_conditioner.sv
// Slide-switch conditioner: two-flop synchroniser plus per-bit debouncer,
// with one-cycle rise/fall pulses and per-bit toggle latches.
module swi_conditioner #(
  parameter int unsigned NBITS           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input logic             clk_2,
  input logic             reset_n,
  swi_conditioner_if.slave swi
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  logic [NBITS-1:0] sync1_q, sync2_q;
  logic [NBITS-1:0] clean_q, clean_d;
  logic [NBITS-1:0] rise_q, rise_d;
  logic [NBITS-1:0] fall_q, fall_d;
  logic [NBITS-1:0] toggle_q, toggle_d;
  logic             any_q, any_d;
  logic [CNT_W-1:0] cnt_q [NBITS];
  logic [CNT_W-1:0] cnt_d [NBITS];

  always_comb begin
    clean_d  = clean_q;
    toggle_d = toggle_q;
    rise_d   = '0;
    fall_d   = '0;
    for (int unsigned i = 0; i < NBITS; i++) begin
      cnt_d[i] = '0;
      // Any return of sync2 to the clean level drops the partial count.
      if (sync2_q[i] != clean_q[i]) begin
        if (cnt_q[i] == CntLast) begin
          clean_d[i]  = sync2_q[i];
          rise_d[i]   = sync2_q[i];
          fall_d[i]   = ~sync2_q[i];
          toggle_d[i] = toggle_q[i] ^ sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntOne;
        end
      end
    end
    any_d = |(rise_d | fall_d);
  end

  always_ff @(posedge clk_2) begin
    if (!reset_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      clean_q  <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      toggle_q <= '0;
      any_q    <= 1'b0;
      for (int unsigned i = 0; i < NBITS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q  <= swi.swi_raw;
      sync2_q  <= sync1_q;
      clean_q  <= clean_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      toggle_q <= toggle_d;
      any_q    <= any_d;
      for (int unsigned i = 0; i < NBITS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign swi.swi_clean    = clean_q;
  assign swi.swi_rise     = rise_q;
  assign swi.swi_fall     = fall_q;
  assign swi.swi_toggle   = toggle_q;
  assign swi.swi_any_edge = any_q;

endmodule

// File: doc/swi_conditioner.md
Name: swi_conditioner

Overview:
- Input-conditioning stage between the board slide switches and the combinational exercise logic in top.
- Synchronises each raw switch bit to clk_2 and debounces it with a per-bit stability counter.
- Produces a clean level vector that replaces direct SWI use downstream.
- Also produces per-bit one-cycle rise/fall pulses and per-bit toggle latches, so later sequential exercises can use the switches as buttons.

Parameters:
- NBITS, 8, number of switch bits conditioned (matches NBITS_TOP).
- DEBOUNCE_CYCLES, 4, consecutive clk_2 cycles a synchronised value must differ from the clean value before it is accepted; legal range 1..255.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), width of each per-bit counter; derived, not overridden.

Ports:
- clk_2  input  1  system clock (divided board clock).
- reset_n  input  1  synchronous active-low reset.
- swi_raw  input  NBITS  asynchronous raw switch levels.
- swi_clean  output  NBITS  debounced, synchronised switch levels.
- swi_rise  output  NBITS  one-cycle pulse when the corresponding clean bit goes 0->1.
- swi_fall  output  NBITS  one-cycle pulse when the corresponding clean bit goes 1->0.
- swi_toggle  output  NBITS  per-bit latch that inverts on every rise of that bit.
- swi_any_edge  output  1  OR-reduction of swi_rise | swi_fall, registered together with them.

Behaviour:
- Clocking and reset: one clock, clk_2. Reset is synchronous and active-low. While reset_n=0 at a rising edge, all state clears: sync1, sync2, swi_clean, counters, swi_rise, swi_fall, swi_toggle, swi_any_edge = 0.
- Synchroniser: per bit, a two-flop chain. sync1 <= swi_raw; sync2 <= sync1. Only sync2 feeds the debouncer.
- Debouncer, per bit i, each rising edge (reset_n=1):
  - sync2[i] == swi_clean[i]: cnt[i] <= 0; no pulse.
  - sync2[i] != swi_clean[i] and cnt[i] < DEBOUNCE_CYCLES-1: cnt[i] <= cnt[i]+1; no pulse.
  - sync2[i] != swi_clean[i] and cnt[i] == DEBOUNCE_CYCLES-1: swi_clean[i] <= sync2[i]; cnt[i] <= 0; swi_rise[i] <= sync2[i]; swi_fall[i] <= ~sync2[i].
  - Any other edge: swi_rise[i] <= 0 and swi_fall[i] <= 0. Pulses last exactly one cycle.
- Latency: swi_raw change stable from before edge 0 appears on swi_clean after rising edge number DEBOUNCE_CYCLES+1, counting from 0 (the DEBOUNCE_CYCLES+2'th edge). Default: 6th edge.
- Pulse timing: rise/fall pulses are asserted in the same cycle swi_clean changes.
- Glitch rejection: if sync2 returns to the clean value before the count completes, the counter clears and nothing changes. A sync2 deviation lasting fewer than DEBOUNCE_CYCLES cycles never reaches swi_clean.
- Counter: never exceeds DEBOUNCE_CYCLES-1; no wrap.
- Toggle: swi_toggle[i] inverts on the same edge that sets swi_rise[i]; swi_fall[i] does not affect it.
- swi_any_edge: registered, equal to |(next swi_rise | next swi_fall), so it is cycle-aligned with the pulses.
- Bit independence: bits are fully independent. Simultaneous changes on several bits yield simultaneous pulses.
- Reset mid-count: counter progress is discarded. After release, a raw bit held at 1 produces a swi_rise (and a toggle) after the full latency, measured from the first edge with reset_n=1.
- DEBOUNCE_CYCLES=1: clean follows sync2 with one cycle of added delay (3-edge total latency).

Test Plan:
- Reset, swi_raw=8'h00 held -> all outputs 0 for 20 cycles; no pulses.
- After reset, swi_raw 8'h00->8'h01 before edge 0 -> swi_clean=8'h01 after edge 5; swi_rise=8'h01 and swi_any_edge=1 for exactly that cycle; swi_toggle=8'h01.
- Bit 3 raw glitch high for 3 cycles then low, DEBOUNCE_CYCLES=4 -> swi_clean, swi_rise, swi_toggle unchanged; counter returns to 0.
- swi_raw=8'hA5 applied at once, then 8'h00 after 20 cycles -> swi_rise=8'hA5 single cycle; later swi_fall=8'hA5 single cycle; swi_toggle stays 8'hA5.
- Bit 0 pressed/released twice (each phase 10 cycles) -> swi_toggle[0] goes 1 then 0; two rise and two fall pulses.
- reset_n driven low 2 cycles after raw 8'hFF applied, held 1 cycle, released -> all outputs 0 during reset; swi_clean=8'hFF exactly 6 edges after release, with one swi_rise=8'hFF pulse.
